// File: rtl/alu_serial_nbit_if.sv
// Handshake and operand/result bundle for the bit-serial ALU.
// master: drives start, a, b, cin, m1, m0; observes f, cout, n, zero, busy, done.
// slave:  the ALU itself, the mirror image of master.
interface alu_serial_nbit_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             m1;
  logic             m0;
  logic [WIDTH-1:0] f;
  logic             cout;
  logic             n;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, cin, m1, m0,
    input  f, cout, n, zero, busy, done
  );

  modport slave (
    input  start, a, b, cin, m1, m0,
    output f, cout, n, zero, busy, done
  );
endinterface

// File: rtl/alu_serial_nbit.sv
// Bit-serial WIDTH-bit ALU (AND/ADD/XOR/SUB), one bit per clock, LSB first.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - slave side of alu_serial_nbit_if:
//          start/a/b/cin/m1/m0 in (latched on an accepted start),
//          f/cout/n/zero registered results, busy while running, done one-cycle pulse.
// Mode {m1,m0}: 00 AND, 01 ADD, 10 XOR, 11 SUB (A + ~B + 1).
module alu_serial_nbit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_serial_nbit_if.slave   bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               accept_c;
  logic               last_c;

  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   res_q;
  logic [1:0]         mode_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   f_q;
  logic               cout_q;
  logic               n_q;
  logic               zero_q;
  logic               busy_q;
  logic               done_q;

  logic               is_sub_c;
  logic               is_arith_c;
  logic               bi_eff_c;
  logic               carry_nx_c;
  logic               rbit_c;
  logic [WIDTH-1:0]   res_nx_c;

  // Single-bit datapath on the current LSBs
  always_comb begin
    is_sub_c   = (mode_q == 2'b11);
    is_arith_c = mode_q[0];
    bi_eff_c   = b_sh_q[0] ^ is_sub_c;
    carry_nx_c = (a_sh_q[0] & bi_eff_c) | (a_sh_q[0] & carry_q) | (bi_eff_c & carry_q);
    case (mode_q)
      2'b00:   rbit_c = a_sh_q[0] & b_sh_q[0];
      2'b10:   rbit_c = a_sh_q[0] ^ b_sh_q[0];
      default: rbit_c = a_sh_q[0] ^ bi_eff_c ^ carry_q;
    endcase
    res_nx_c = {rbit_c, res_q[WIDTH-1:1]};
    last_c   = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = RUN;
          accept_c = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (last_c) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand/result shift registers, carry and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      mode_q  <= 2'b00;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept_c) begin
      a_sh_q  <= bus.a;
      b_sh_q  <= bus.b;
      res_q   <= '0;
      mode_q  <= {bus.m1, bus.m0};
      // SUB seeds the +1 of two's complement; ADD seeds cin; logic ops keep 0
      carry_q <= bus.m0 & (bus.m1 | bus.cin);
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_sh_q  <= a_sh_q >> 1;
      b_sh_q  <= b_sh_q >> 1;
      res_q   <= res_nx_c;
      if (is_arith_c) carry_q <= carry_nx_c;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Visible results update only on the completing bit edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q    <= '0;
      cout_q <= 1'b0;
      n_q    <= 1'b0;
      zero_q <= 1'b0;
    end else if (state_q == RUN && last_c) begin
      f_q    <= res_nx_c;
      cout_q <= is_arith_c & carry_nx_c;
      n_q    <= is_sub_c ? ~carry_nx_c : rbit_c;
      zero_q <= (res_nx_c == '0);
    end
  end

  // Handshake flags registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == RUN);
      done_q <= (state_q == RUN) && (state_d == DONE);
    end
  end

  assign bus.f    = f_q;
  assign bus.cout = cout_q;
  assign bus.n    = n_q;
  assign bus.zero = zero_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_alu_serial_nbit.sv
// Scoreboard bench for alu_serial_nbit (WIDTH=4): the driver pushes expected
// results with their due cycle; a monitor pops and compares on every done.
module tb_alu_serial_nbit;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_serial_nbit_if #(.WIDTH(W)) bus();

  alu_serial_nbit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] f;
    logic         cout;
    logic         n;
    logic         zero;
    logic [31:0]  due;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.done) begin
      check("busy_done_exclusive", {31'd0, bus.busy}, 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("f",       {28'd0, bus.f},    {28'd0, e.f});
        check("cout",    {31'd0, bus.cout}, {31'd0, e.cout});
        check("n",       {31'd0, bus.n},    {31'd0, e.n});
        check("zero",    {31'd0, bus.zero}, {31'd0, e.zero});
        check("latency", cyc,               e.due);
      end
    end
  end

  // Drive one request for a single cycle; optionally expect its result
  task automatic issue(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic push,
                       input logic [W-1:0] ef, input logic ec, input logic en, input logic ez);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; {bus.m1, bus.m0} = m; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (push) sb.push_back('{f: ef, cout: ec, n: en, zero: ez, due: 32'(cyc + W)});
  endtask

  localparam logic [1:0] OP_AND = 2'b00, OP_ADD = 2'b01, OP_XOR = 2'b10, OP_SUB = 2'b11;

  initial begin
    int busy_cnt;
    int unsigned acc;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.m1 = 1'b0; bus.m0 = 1'b0;

    #2 rst = 1'b1;
    #1 check("reset_outputs", {26'd0, bus.f, bus.cout, bus.n, bus.zero, bus.busy, bus.done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ADD 7+3, and busy must last exactly W cycles
    issue(OP_ADD, 4'b0111, 4'b0011, 1'b0, 1'b1, 4'b1010, 1'b0, 1'b1, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(busy_cnt), 32'd4);

    issue(OP_ADD, 4'b1111, 4'b0001, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1); repeat (6) @(negedge clk);
    issue(OP_ADD, 4'b0010, 4'b0001, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0); repeat (6) @(negedge clk);
    issue(OP_SUB, 4'b0011, 4'b0101, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b1, 1'b0); repeat (6) @(negedge clk);
    issue(OP_SUB, 4'b0101, 4'b0101, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1); repeat (6) @(negedge clk);
    issue(OP_SUB, 4'b0000, 4'b0001, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0); repeat (6) @(negedge clk);
    issue(OP_AND, 4'b1100, 4'b1010, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0); repeat (6) @(negedge clk);
    issue(OP_AND, 4'b1111, 4'b0101, 1'b1, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0); repeat (6) @(negedge clk);
    issue(OP_XOR, 4'b1100, 4'b1010, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0); repeat (6) @(negedge clk);

    // Second start during RUN with new operands must be ignored
    issue(OP_ADD, 4'b0111, 4'b0011, 1'b0, 1'b1, 4'b1010, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.a = 4'b1111; bus.b = 4'b1111; {bus.m1, bus.m0} = OP_SUB; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);

    // Reset in the second RUN cycle: outputs clear at once, no done follows
    issue(OP_ADD, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("abort_outputs", {26'd0, bus.f, bus.cout, bus.n, bus.zero, bus.busy, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // start held high through DONE: second op accepted straight from DONE
    bus.a = 4'b1010; bus.b = 4'b0101; bus.cin = 1'b0; {bus.m1, bus.m0} = OP_XOR; bus.start = 1'b1;
    @(negedge clk);
    acc = cyc;
    sb.push_back('{f: 4'b1111, cout: 1'b0, n: 1'b1, zero: 1'b0, due: 32'(acc + W)});
    bus.a = 4'b1000; bus.b = 4'b0001; {bus.m1, bus.m0} = OP_SUB;
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    sb.push_back('{f: 4'b0111, cout: 1'b1, n: 1'b0, zero: 1'b0, due: 32'(acc + W + 5)});
    repeat (8) @(negedge clk);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
